load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
CPU-side initiator that drives the data memory port: `addr`, `w_d`, `w_e` out, with `r_d` consumed combinationally. It accepts one load/store request at a time from the execute stage over a valid/ready handshake. It supports byte, halfword and word accesses, with sign/zero extension on loads and read-modify-write for sub-word stores. It returns a single-cycle response pulse carrying load data or an alignment error.

Parameters:
- MEM_WORDS, 256, number of 32-bit words behind the port; the word index is addr[log2(MEM_WORDS)+1:2].
- ADDR_W, 32, request/memory address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid&&req_ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- req_signed  in  1  loads: sign-extend when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_err  out  1  misaligned/reserved-size/out-of-range; valid with resp_valid
- mem_addr  out  ADDR_W  to memory addr
- mem_w_d  out  32  to memory w_d
- mem_w_e  out  1  to memory w_e
- mem_r_d  in  32  from memory r_d, combinational, valid only while mem_w_e=0

Behaviour:
- Reset (async): state IDLE. All outputs 0 except req_ready=1. An in-flight request is dropped with no response and no write.
- FSM states: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- IDLE:
  - req_ready=1; on accept, latch all req_* fields.
  - Error check: size==3, half with addr[0]!=0, or word with addr[1:0]!=0.
  - On error → RESP with err=1; memory is never written.
  - Load or word store → ACCESS.
  - Byte/half store → RMW_RD.
- ACCESS (1 cycle):
  - mem_addr = {latched addr[ADDR_W-1:2], 2'b00}.
  - Word store: mem_w_e=1, mem_w_d=wdata.
  - Load: mem_w_e=0; capture mem_r_d at the clock edge.
  - Next state: RESP.
- RMW_RD (1 cycle): mem_w_e=0; capture mem_r_d into the merge register → RMW_WR.
- RMW_WR (1 cycle): mem_w_e=1; mem_w_d = captured word with the selected lane replaced. Lanes are little-endian: byte lane = addr[1:0]; half lane = addr[1]. Next state: RESP.
- RESP (1 cycle): resp_valid=1 → IDLE.
  - resp_rdata: lane extracted from the captured word, sign-extended if signed, else zero-extended.
- Latency, accept edge to resp_valid: load/word store 2 cycles, sub-word store 3 cycles, error 1 cycle.
- Back-to-back: a new accept is possible the cycle after RESP; maximum throughput is one request per 3 cycles.
- mem_w_e is high only in ACCESS (word store) and RMW_WR. It is a registered state decode, glitch-free.
- Outside memory phases (IDLE/RESP): mem_addr holds its last value, mem_w_e=0, mem_w_d=0.
- req_* changes while not ready are ignored.

Optional Feature:
- Macro LSU_RANGE_CHECK_EN.
- Defined: the IDLE error check also flags req_addr >= MEM_WORDS*4 (resp_err=1, no memory access).
- Undefined: upper address bits are passed through, and the memory aliases them by decoding only the index bits.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state enum.
  - Function for the lane-extract-and-extend.
  - Function for the lane-merge.
- One natural sub-module: lsu_lane_align, combinational extract/extend and merge shared by the load and RMW paths.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 → resp_rdata=0xDEADBEEF, err=0; resp_valid 2 cycles after each accept.
- Byte store 0x80 @0x11 onto word 0x11223344, then signed lb @0x11 → 0xFFFFFF80; unsigned → 0x00000080; word load @0x10 → 0x11228044.
- Half store 0xABCD @0x22 onto word 0; word load @0x20 → 0xABCD0000; exactly one mem_w_e cycle, preceded by one read cycle.
- Misaligned lw @0x06, sh @0x03, size=3 → resp_err=1 after 1 cycle, mem_w_e never high, memory unchanged.
- rst_n low during RMW_RD of a byte store → no resp_valid, mem_w_e=0 immediately, target word unchanged, req_ready=1 after release.
- With LSU_RANGE_CHECK_EN, lw @0x400 (MEM_WORDS=256) → resp_err=1; without it → returns word @0x000.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit: access-size codes,
// FSM states, and the little-endian lane extract/merge functions.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RMW_RD,
        RMW_WR,
        RESP
    } state_e;

    // Pull the addressed lane out of a word and sign- or zero-extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input size_e       size,
                                                 input logic        sext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: lane_extract = {{24{sext & b[7]}}, b};
            SZ_HALF: lane_extract = {{16{sext & h[15]}}, h};
            default: lane_extract = word;
        endcase
    endfunction

    // Replace the addressed lane of a word with right-aligned store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  lane,
                                               input size_e       size);
        logic [31:0] mask;
        case (size)
            SZ_BYTE: mask = 32'h0000_00ff;
            SZ_HALF: mask = 32'h0000_ffff;
            default: mask = 32'hffff_ffff;
        endcase
        mask       = mask << {lane, 3'b000};
        lane_merge = (word & ~mask) | ((data << {lane, 3'b000}) & mask);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment shared by the load path (extract/extend)
// and the read-modify-write path (merge).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        sext,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    assign load_data = lane_extract(word, lane, size, sext);
    assign merged    = lane_merge(word, wdata, lane, size);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a combinational-read data memory.
// Define LSU_RANGE_CHECK_EN to flag byte addresses beyond MEM_WORDS*4 as errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_w_d,
    output logic              mem_w_e,
    input  logic [31:0]       mem_r_d
);

    if ($clog2(MEM_WORDS) + 2 > ADDR_W) begin : g_cfg_check
        $error("MEM_WORDS does not fit in ADDR_W");
    end

    state_e            state, state_next;
    logic              we_q, sext_q, err_q;
    size_e             size_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q, rdata_q;
    logic              accept, req_err;
    logic [31:0]       load_data, merged;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [31:0]       mem_w_d_next;
    logic              mem_w_e_next;

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign word_addr  = {req_addr[ADDR_W-1:2], 2'b00};
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;

`ifdef LSU_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS * 4);
`endif

    always_comb begin
        req_err = (req_size == SZ_RSVD)
               || (req_size == SZ_HALF && req_addr[0])
               || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`ifdef LSU_RANGE_CHECK_EN
        if ({1'b0, req_addr} >= ADDR_LIMIT) req_err = 1'b1;
`endif
    end

    // The merge sees the live read word during RMW_RD, so its result is
    // registered straight into mem_w_d for the RMW_WR cycle.
    lsu_lane_align u_align (
        .word      (mem_r_d),
        .wdata     (wdata_q),
        .lane      (lane_q),
        .size      (size_q),
        .sext      (sext_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path
        // through the case statements can leave a value held and infer a latch.
        state_next    = state;
        mem_addr_next = mem_addr;
        mem_w_e_next  = 1'b0;
        mem_w_d_next  = 32'h0;
        case (state)
            IDLE: if (accept) begin
                if (req_err)                           state_next = RESP;
                else if (req_we && req_size != SZ_WORD) state_next = RMW_RD;
                else                                    state_next = ACCESS;
            end
            ACCESS:  state_next = RESP;
            RMW_RD:  state_next = RMW_WR;
            RMW_WR:  state_next = RESP;
            default: state_next = IDLE;
        endcase
        // Memory outputs are decoded from the next state and registered.
        case (state_next)
            ACCESS: begin
                mem_addr_next = word_addr;
                mem_w_e_next  = req_we;
                mem_w_d_next  = req_we ? req_wdata : 32'h0;
            end
            RMW_RD: mem_addr_next = word_addr;
            RMW_WR: begin
                mem_w_e_next = 1'b1;
                mem_w_d_next = merged;
            end
            default: ;
        endcase
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_addr <= '0;
            mem_w_e  <= 1'b0;
            mem_w_d  <= 32'h0;
            we_q     <= 1'b0;
            sext_q   <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= SZ_BYTE;
            lane_q   <= 2'b00;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state    <= state_next;
            mem_addr <= mem_addr_next;
            mem_w_e  <= mem_w_e_next;
            mem_w_d  <= mem_w_d_next;
            if (accept) begin
                we_q    <= req_we;
                sext_q  <= req_signed;
                err_q   <= req_err;
                size_q  <= size_e'(req_size);
                lane_q  <= req_addr[1:0];
                wdata_q <= req_wdata;
                rdata_q <= 32'h0;
            end
            if (state == ACCESS && !we_q) rdata_q <= load_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: a byte-level reference
// memory predicts responses and write cycles, checked every cycle.
module tb_load_store_unit;

    localparam int MEM_WORDS = 256;
    localparam int ADDR_W    = 32;
    localparam int IDX_HI    = $clog2(MEM_WORDS) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              req_valid, req_ready, req_we, req_signed;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid, resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_w_d, mem_r_d;
    logic              mem_w_e;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit run_chk = 1'b0;

    typedef struct { int due; logic [31:0] rdata; logic err; } resp_exp_t;
    typedef struct { int due; logic [31:0] addr; } wr_exp_t;
    resp_exp_t resp_q[$];
    wr_exp_t   wr_q[$];

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_w_d    (mem_w_d),
        .mem_w_e    (mem_w_e),
        .mem_r_d    (mem_r_d)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: combinational read, synchronous write, index bits only.
    assign mem_r_d = mem[mem_addr[IDX_HI:2]];
    always @(posedge clk) if (mem_w_e) mem[mem_addr[IDX_HI:2]] <= mem_w_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec-level model: works on bytes of the reference memory and queues the
    // response and write cycle each request must produce.
    task automatic model_push(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata, input int c0);
        logic        err;
        int          idx, b, n;
        logic [31:0] val;
        resp_exp_t   r;
        wr_exp_t     w;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
`ifdef LSU_RANGE_CHECK_EN
        if (addr >= 32'(MEM_WORDS * 4)) err = 1'b1;
`endif
        idx = int'((addr >> 2) % MEM_WORDS);
        b   = int'(addr % 4);
        n   = 1 << int'(size);
        val = 32'h0;
        if (err) begin
            r = '{due: c0 + 1, rdata: 32'h0, err: 1'b1};
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[idx][8*(b+i) +: 8] = wdata[8*i +: 8];
            w = '{due: (n == 4) ? c0 + 1 : c0 + 2, addr: {addr[31:2], 2'b00}};
            wr_q.push_back(w);
            r = '{due: (n == 4) ? c0 + 2 : c0 + 3, rdata: 32'h0, err: 1'b0};
        end else begin
            for (int i = 0; i < n; i++) val[8*i +: 8] = ref_mem[idx][8*(b+i) +: 8];
            if (sgn && n < 4 && val[8*n-1])
                for (int i = 8 * n; i < 32; i++) val[i] = 1'b1;
            r = '{due: c0 + 2, rdata: val, err: 1'b0};
        end
        resp_q.push_back(r);
    endtask

    // Cycle-by-cycle comparison against the model's queued expectations.
    always @(negedge clk) begin : compare
        bit exp_v, exp_we;
        if (run_chk && rst_n) begin
            exp_v = resp_q.size() > 0 && resp_q[0].due == cyc;
            check("resp_valid", 32'(resp_valid), 32'(exp_v));
            if (exp_v) begin
                check("resp_rdata", resp_rdata, resp_q[0].rdata);
                check("resp_err", 32'(resp_err), 32'(resp_q[0].err));
                void'(resp_q.pop_front());
            end
            exp_we = wr_q.size() > 0 && wr_q[0].due == cyc;
            check("mem_w_e", 32'(mem_w_e), 32'(exp_we));
            if (exp_we) begin
                check("mem_addr_wr", mem_addr, wr_q[0].addr);
                void'(wr_q.pop_front());
            end
        end
    end

    // Called at a falling edge; returns at the falling edge of the response cycle.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
        bit got;
        rdata = 32'h0;
        err   = 1'b0;
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (req_ready) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        model_push(we, size, sgn, addr, wdata, cyc);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got   = 1'b1;
                rdata = resp_rdata;
                err   = resp_err;
            end
        end
        if (!got) check("resp_timeout", 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] rd;
        logic        er;
        bit          busy;
        // NOTE: the memory is initialised once and never on reset, matching a
        // real SRAM whose contents survive rst_n.
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_w_d", mem_w_d, 32'h0);
        check("rst_mem_w_e", 32'(mem_w_e), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_chk = 1'b1;

        // Word store then word load.
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
        check("sw_err", 32'(er), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
        check("lw_10", rd, 32'hDEADBEEF);
        check("lw_10_err", 32'(er), 32'd0);

        // Byte store with read-modify-write, then byte and word reloads.
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, rd, er);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000080, rd, er);
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, rd, er);
        check("lb_11", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, rd, er);
        check("lbu_11", rd, 32'h00000080);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
        check("lw_10_merged", rd, 32'h11228044);

        // Halfword store into the upper lane of a zero word.
        do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000ABCD, rd, er);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
        check("lw_20", rd, 32'hABCD0000);
        do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, rd, er);
        check("lh_22", rd, 32'hFFFFABCD);
        do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, rd, er);
        check("lhu_22", rd, 32'h0000ABCD);
        do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, rd, er);
        check("lbu_23", rd, 32'h000000AB);

        // Alignment and reserved-size errors: no memory write may happen.
        do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, rd, er);
        check("lw_06_err", 32'(er), 32'd1);
        check("lw_06_rdata", rd, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h03, 32'h00001234, rd, er);
        check("sh_03_err", 32'(er), 32'd1);
        do_req(1'b0, 2'd3, 1'b0, 32'h30, 32'h0, rd, er);
        check("size3_err", 32'(er), 32'd1);
        do_req(1'b1, 2'd2, 1'b0, 32'h31, 32'hFFFFFFFF, rd, er);
        check("sw_31_err", 32'(er), 32'd1);
        check("mem0_untouched", mem[0], 32'h0);
        check("mem12_untouched", mem[12], 32'h0);

        // Reset while a byte store sits in its read phase.
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h00000055; req_valid = 1'b1;
        check("rst_test_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw_rd_no_write", 32'(mem_w_e), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_w_e", 32'(mem_w_e), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        busy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid || mem_w_e) busy = 1'b1;
        end
        check("abort_quiet", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("abort_word_kept", mem[8], 32'hABCD0000);

        // Address beyond the memory: error when range-checked, else aliases to word 0.
        do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, rd, er);
        do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, rd, er);
`ifdef LSU_RANGE_CHECK_EN
        check("lw_400_err", 32'(er), 32'd1);
        check("lw_400_rdata", rd, 32'h0);
`else
        check("lw_400_err", 32'(er), 32'd0);
        check("lw_400_alias", rd, 32'hCAFEF00D);
`endif

        repeat (3) @(negedge clk);
        check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        check("write_queue_drained", 32'(wr_q.size()), 32'd0);
        for (int i = 0; i < MEM_WORDS; i++)
            check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
